// File: rtl/dcache_mem_bridge.sv
// Serialises Dcache mem-port requests onto a 32-bit, one-outstanding word bus.
// Refills issue one read per line word; uncached reads and writes issue a single word.
module dcache_mem_bridge #(
  parameter int offset_width = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 dcache_mem_req,
  input  logic                                 dcache_mem_wr,
  input  logic                                 dcache_mem_SUC,
  input  logic [1:0]                           dcache_mem_size,
  input  logic [3:0]                           dcache_mem_wstrb,
  input  logic [31:0]                          addr_dcache_mem,
  input  logic [31:0]                          dout_dcache_mem,
  output logic                                 mem_dcache_addrOK,
  output logic                                 mem_dcache_dataOK,
  output logic [32*(1<<offset_width)-1:0]      din_mem_dcache,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_wr,
  output logic [31:0]                          mem_req_addr,
  output logic [31:0]                          mem_req_wdata,
  output logic [3:0]                           mem_req_wstrb,
  output logic [1:0]                           mem_req_size,
  input  logic                                 mem_resp_valid,
  input  logic [31:0]                          mem_resp_rdata
);

  localparam int WORDS = 1 << offset_width;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [offset_width-1:0] LAST_CNT = '1;

  logic [1:0]              r_state;
  logic [offset_width-1:0] r_cnt;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_wr;
  logic                    r_suc;
  logic [1:0]              r_size;
  logic [3:0]              r_wstrb;

  logic w_refill;
  logic w_accept;
  logic w_in_req;
  logic w_resp;
  logic w_last;
  logic [31:0] w_addr;

  assign w_refill = !r_wr && !r_suc;
  assign w_accept = (r_state == IDLE) && dcache_mem_req;
  assign w_in_req = (r_state == REQ);
  assign w_resp   = (r_state == WAIT) && mem_resp_valid;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_addr   = w_refill ? {r_addr[31:2+offset_width], r_cnt, 2'b00} : r_addr;

  // addrOK is combinational; gating with rstn keeps it low while reset is held.
  assign mem_dcache_addrOK = rstn && w_accept;
  assign mem_dcache_dataOK = (r_state == DONE);
  assign mem_req_valid     = w_in_req;
  assign mem_req_wr        = w_in_req && r_wr;
  assign mem_req_addr      = w_in_req ? w_addr : 32'd0;
  assign mem_req_wdata     = (w_in_req && r_wr) ? r_wdata : 32'd0;
  assign mem_req_wstrb     = !w_in_req ? 4'd0 : (r_wr ? r_wstrb : 4'b1111);
  assign mem_req_size      = !w_in_req ? 2'd0 : (w_refill ? 2'd2 : r_size);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_suc   <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dcache_mem_req) begin
            r_addr  <= addr_dcache_mem;
            r_wdata <= dout_dcache_mem;
            r_wr    <= dcache_mem_wr;
            r_suc   <= dcache_mem_SUC;
            r_size  <= dcache_mem_size;
            r_wstrb <= dcache_mem_wstrb;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (w_refill && !w_last) begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= REQ;
            end else begin
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One register per line word; an uncached read only ever lands in word 0.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_line
    localparam logic [offset_width-1:0] IDX = gi;
    logic [31:0] r_word;
    logic        w_wen;

    assign w_wen = w_resp && !r_wr && (w_refill ? (r_cnt == IDX) : (gi == 0));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_word <= 32'd0;
      end else if (w_wen) begin
        r_word <= mem_resp_rdata;
      end
    end

    assign din_mem_dcache[32*gi +: 32] = r_word;
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: refill, uncached read, write, stall, reset, back-to-back.
module tb_dcache_mem_bridge;

  logic         clk;
  logic         rstn;
  logic         dcache_mem_req;
  logic         dcache_mem_wr;
  logic         dcache_mem_SUC;
  logic [1:0]   dcache_mem_size;
  logic [3:0]   dcache_mem_wstrb;
  logic [31:0]  addr_dcache_mem;
  logic [31:0]  dout_dcache_mem;
  logic         mem_dcache_addrOK;
  logic         mem_dcache_dataOK;
  logic [127:0] din_mem_dcache;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_wr;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic [3:0]   mem_req_wstrb;
  logic [1:0]   mem_req_size;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cyc0;

  dcache_mem_bridge #(.offset_width(2)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .dcache_mem_req    (dcache_mem_req),
    .dcache_mem_wr     (dcache_mem_wr),
    .dcache_mem_SUC    (dcache_mem_SUC),
    .dcache_mem_size   (dcache_mem_size),
    .dcache_mem_wstrb  (dcache_mem_wstrb),
    .addr_dcache_mem   (addr_dcache_mem),
    .dout_dcache_mem   (dout_dcache_mem),
    .mem_dcache_addrOK (mem_dcache_addrOK),
    .mem_dcache_dataOK (mem_dcache_dataOK),
    .din_mem_dcache    (din_mem_dcache),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_wr        (mem_req_wr),
    .mem_req_addr      (mem_req_addr),
    .mem_req_wdata     (mem_req_wdata),
    .mem_req_wstrb     (mem_req_wstrb),
    .mem_req_size      (mem_req_size),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_rdata    (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a request in the current cycle and expect it accepted at once.
  task automatic issue(input logic wr, input logic suc, input logic [1:0] size,
                       input logic [3:0] wstrb, input logic [31:0] addr, input logic [31:0] wdata);
    dcache_mem_req   = 1'b1;
    dcache_mem_wr    = wr;
    dcache_mem_SUC   = suc;
    dcache_mem_size  = size;
    dcache_mem_wstrb = wstrb;
    addr_dcache_mem  = addr;
    dout_dcache_mem  = wdata;
    #1;
    check("addrOK", 128'(mem_dcache_addrOK), 128'd1);
    cyc0 = cyc;
    step();
  endtask

  // Called in the cycle a word request is due: checks fields, stalls, then answers next cycle.
  task automatic bus_word(input string tag, input logic [31:0] eaddr, input logic ewr,
                          input logic [31:0] ewdata, input logic [3:0] ewstrb,
                          input logic [1:0] esize, input int stall, input logic [31:0] rdata);
    #1;
    check({tag, " valid"}, 128'(mem_req_valid), 128'd1);
    check({tag, " addr"},  128'(mem_req_addr),  128'(eaddr));
    check({tag, " wr"},    128'(mem_req_wr),    128'(ewr));
    check({tag, " size"},  128'(mem_req_size),  128'(esize));
    if (ewr) begin
      check({tag, " wdata"}, 128'(mem_req_wdata), 128'(ewdata));
      check({tag, " wstrb"}, 128'(mem_req_wstrb), 128'(ewstrb));
    end else if (!dut.r_suc) begin
      check({tag, " wstrb"}, 128'(mem_req_wstrb), 128'hF);
    end
    for (int s = 0; s < stall; s++) begin
      mem_req_ready = 1'b0;
      step();
      #1;
      check({tag, " stall valid"}, 128'(mem_req_valid), 128'd1);
      check({tag, " stall addr"},  128'(mem_req_addr),  128'(eaddr));
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    #1;
    check({tag, " wait valid"}, 128'(mem_req_valid), 128'd0);
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'd0;
  endtask

  initial begin
    rstn = 1'b0;
    dcache_mem_req = 0; dcache_mem_wr = 0; dcache_mem_SUC = 0;
    dcache_mem_size = 0; dcache_mem_wstrb = 0; addr_dcache_mem = 0; dout_dcache_mem = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    step();
    step();
    check("rst valid",  128'(mem_req_valid),     128'd0);
    check("rst dataOK", 128'(mem_dcache_dataOK), 128'd0);
    check("rst line",   din_mem_dcache,          128'd0);
    rstn = 1'b1;
    step();

    // 1: refill with minimum latency
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h1000_0038, 32'd0);
    dcache_mem_req = 1'b0;
    check("busy addrOK", 128'(mem_dcache_addrOK), 128'd0);
    bus_word("rf w0", 32'h1000_0030, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hA0A0_0000);
    bus_word("rf w1", 32'h1000_0034, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hA1A1_1111);
    bus_word("rf w2", 32'h1000_0038, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hA2A2_2222);
    bus_word("rf w3", 32'h1000_003C, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hA3A3_3333);
    check("rf dataOK",  128'(mem_dcache_dataOK), 128'd1);
    check("rf latency", 128'(cyc - cyc0),        128'd9);
    check("rf line", din_mem_dcache, 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000);
    step();
    check("rf dataOK pulse", 128'(mem_dcache_dataOK), 128'd0);
    check("rf line held", din_mem_dcache, 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000);

    // 2: uncached read replaces word 0 only
    issue(1'b0, 1'b1, 2'd2, 4'd0, 32'hBFD0_0004, 32'd0);
    dcache_mem_req = 1'b0;
    bus_word("suc", 32'hBFD0_0004, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'h5555_1234);
    check("suc dataOK",  128'(mem_dcache_dataOK), 128'd1);
    check("suc latency", 128'(cyc - cyc0),        128'd3);
    check("suc line", din_mem_dcache, 128'hA3A3_3333_A2A2_2222_A1A1_1111_5555_1234);
    step();

    // 3: byte write; Dcache inputs change right after addrOK
    issue(1'b1, 1'b0, 2'd0, 4'b0010, 32'h2000_0001, 32'h0000_AB00);
    dcache_mem_req = 1'b0; addr_dcache_mem = 32'hDEAD_BEEF; dout_dcache_mem = 32'hFFFF_FFFF;
    dcache_mem_wstrb = 4'hF; dcache_mem_size = 2'd2;
    bus_word("wr", 32'h2000_0001, 1'b1, 32'h0000_AB00, 4'b0010, 2'd0, 0, 32'h9999_9999);
    check("wr dataOK", 128'(mem_dcache_dataOK), 128'd1);
    check("wr line", din_mem_dcache, 128'hA3A3_3333_A2A2_2222_A1A1_1111_5555_1234);
    step();

    // 4: refill with ready low for 3 cycles on word 2
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h0000_2000, 32'd0);
    dcache_mem_req = 1'b0;
    bus_word("st w0", 32'h0000_2000, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hB0B0_0000);
    bus_word("st w1", 32'h0000_2004, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hB1B1_1111);
    bus_word("st w2", 32'h0000_2008, 1'b0, 32'd0, 4'hF, 2'd2, 3, 32'hB2B2_2222);
    bus_word("st w3", 32'h0000_200C, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hB3B3_3333);
    check("st dataOK",  128'(mem_dcache_dataOK), 128'd1);
    check("st latency", 128'(cyc - cyc0),        128'd12);
    check("st line", din_mem_dcache, 128'hB3B3_3333_B2B2_2222_B1B1_1111_B0B0_0000);
    step();

    // 5: reset while waiting for word 1, late response afterwards
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h3000_0000, 32'd0);
    dcache_mem_req = 1'b0;
    bus_word("rs w0", 32'h3000_0000, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'hC0C0_0000);
    #1;
    check("rs w1 addr", 128'(mem_req_addr), 128'h3000_0004);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("rs valid",  128'(mem_req_valid),     128'd0);
    check("rs dataOK", 128'(mem_dcache_dataOK), 128'd0);
    check("rs line",   din_mem_dcache,          128'd0);
    check("rs addr",   128'(mem_req_addr),      128'd0);
    step();
    rstn = 1'b1;
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hC1C1_1111;
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      check("rs post dataOK", 128'(mem_dcache_dataOK), 128'd0);
      check("rs post valid",  128'(mem_req_valid),     128'd0);
      step();
    end
    check("rs post line", din_mem_dcache, 128'd0);

    // 6: stray response in IDLE, then back-to-back uncached reads
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_0000;
    step();
    mem_resp_valid = 1'b0;
    #1;
    check("stray line",  din_mem_dcache,        128'd0);
    check("stray valid", 128'(mem_req_valid),   128'd0);
    issue(1'b0, 1'b1, 2'd2, 4'd0, 32'h0000_0040, 32'd0);
    addr_dcache_mem = 32'h0000_0044;
    #1;
    check("b2b busy addrOK", 128'(mem_dcache_addrOK), 128'd0);
    bus_word("b2b a", 32'h0000_0040, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'h1111_0040);
    check("b2b a dataOK",      128'(mem_dcache_dataOK), 128'd1);
    check("b2b DONE addrOK",   128'(mem_dcache_addrOK), 128'd0);
    check("b2b a line", din_mem_dcache, 128'h1111_0040);
    step();
    issue(1'b0, 1'b1, 2'd2, 4'd0, 32'h0000_0044, 32'd0);
    dcache_mem_req = 1'b0;
    bus_word("b2b b", 32'h0000_0044, 1'b0, 32'd0, 4'hF, 2'd2, 0, 32'h2222_0044);
    check("b2b b dataOK", 128'(mem_dcache_dataOK), 128'd1);
    check("b2b b line", din_mem_dcache, 128'h2222_0044);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
